// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default latencies
// and the latency-counter width helper.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        CTR_IDLE = 1'b0,
        CTR_RUN  = 1'b1
    } ctr_state_e;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    function automatic int mdu_ctr_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

    localparam int MDU_CTR_W = mdu_ctr_width(MDU_MULT_CYCLES_DEF, MDU_DIV_CYCLES_DEF);

endpackage

// File: rtl/mdu_latency_ctr.sv
// Busy-latency down-counter for the MDU; owns the IDLE/RUN state.
// state | meaning
// IDLE  | no operation in flight, load accepted
// RUN   | counting down, done pulses on the edge where cnt==1
module mdu_latency_ctr
    import mdu_pkg::*;
#(
    parameter int W = MDU_CTR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         busy,
    output logic         done
);

    ctr_state_e   state, state_d;
    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CTR_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            if (state == CTR_IDLE && load)
                cnt <= load_val;
            else if (state == CTR_RUN)
                cnt <= cnt - W'(1);
        end
    end

    always_comb begin
        state_d = state;
        done    = 1'b0;
        case (state)
            CTR_IDLE: if (load) state_d = CTR_RUN;
            CTR_RUN: begin
                if (cnt == W'(1)) begin
                    done    = 1'b1;
                    state_d = CTR_IDLE;
                end
            end
            default: state_d = CTR_IDLE;
        endcase
    end

    assign busy = (state == CTR_RUN);

endmodule

// File: rtl/mul_div_unit.sv
// E-stage multiply/divide unit with HI/LO registers and emulated latency.
// Define MDU_DIVZERO_EN for the fast, defined-result divide-by-zero behaviour.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        read_hi,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic [31:0] rd_data
);

    localparam int CTR_W = mdu_ctr_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [CTR_W-1:0] MULT_LOAD = CTR_W'(MULT_CYCLES);
    localparam logic [CTR_W-1:0] DIV_LOAD  = CTR_W'(DIV_CYCLES);

    mdu_op_e          op;
    logic             is_signed, a_neg, b_neg, div_zero, done;
    logic [63:0]      prod;
    logic [31:0]      a_mag, b_mag, q_mag, r_mag;
    logic [31:0]      res_hi, res_lo, pend_hi, pend_lo;
    logic [CTR_W-1:0] load_val;

    assign op       = mdu_op_e'(mdu_op);
    assign start    = req_valid && (op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU}) && !busy;
    assign div_zero = (src_b == 32'd0);

    // One unsigned datapath serves both signednesses: sign-extend for the
    // product, take magnitudes for the quotient and fix signs afterwards.
    assign is_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign a_neg     = is_signed && src_a[31];
    assign b_neg     = is_signed && src_b[31];
    assign prod      = {{32{a_neg}}, src_a} * {{32{b_neg}}, src_b};
    assign a_mag     = a_neg ? -src_a : src_a;
    assign b_mag     = b_neg ? -src_b : src_b;
    assign q_mag     = a_mag / b_mag;
    assign r_mag     = a_mag % b_mag;

    always_comb begin
        res_hi   = hi_out;
        res_lo   = lo_out;
        load_val = MULT_LOAD;
        case (op)
            MDU_MULT, MDU_MULTU: begin
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            MDU_DIV, MDU_DIVU: begin
                load_val = DIV_LOAD;
                if (div_zero) begin
`ifdef MDU_DIVZERO_EN
                    load_val = CTR_W'(1);
                    res_hi   = src_a;
                    res_lo   = (op == MDU_DIV && src_a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
`else
                    res_hi   = hi_out;
                    res_lo   = lo_out;
`endif
                end else begin
                    res_lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
                    res_hi = a_neg ? -r_mag : r_mag;
                end
            end
            default: ;
        endcase
    end

    mdu_latency_ctr #(.W(CTR_W)) u_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (start),
        .load_val (load_val),
        .busy     (busy),
        .done     (done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_hi <= '0;
            pend_lo <= '0;
        end else if (start) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_out <= '0;
            lo_out <= '0;
        end else if (done) begin
            hi_out <= pend_hi;
            lo_out <= pend_lo;
        end else if (req_valid && !busy) begin
            if (op == MDU_MTHI) hi_out <= src_a;
            if (op == MDU_MTLO) lo_out <= src_a;
        end
    end

    assign rd_data = read_hi ? hi_out : lo_out;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: arithmetic reference model plus directed vectors.
// Honours MDU_DIVZERO_EN for the divide-by-zero expectations.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  mdu_op = 3'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        read_hi = 1'b0;
    logic        start, busy;
    logic [31:0] hi_out, lo_out, rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .mdu_op    (mdu_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .read_hi   (read_hi),
        .start     (start),
        .busy      (busy),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, want, $time);
        end
    endtask

    // Reference model: architectural HI/LO plus remaining busy cycles.
    logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
    int          m_left = 0;
    int          busy_req_seen = 0;
    longint      sa, sb, sp, sq, sr;
    logic [63:0] up;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; m_left = 0;
        end else if (m_left > 0) begin
            if (req_valid && mdu_op >= 3'd1 && mdu_op <= 3'd6) begin
                busy_req_seen++;
                $display("note: MDU request while busy at %0t (ignored)", $time);
            end
            m_left--;
            if (m_left == 0) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (req_valid) begin
            sa = longint'($signed(src_a));
            sb = longint'($signed(src_b));
            case (mdu_op)
                3'd1: begin sp = sa * sb; m_phi = sp[63:32]; m_plo = sp[31:0]; m_left = 5; end
                3'd2: begin up = {32'd0, src_a} * {32'd0, src_b}; m_phi = up[63:32]; m_plo = up[31:0]; m_left = 5; end
                3'd3, 3'd4: begin
                    if (src_b == 0) begin
`ifdef MDU_DIVZERO_EN
                        m_left = 1;
                        m_phi  = src_a;
                        m_plo  = (mdu_op == 3'd3 && sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
`else
                        m_left = 10;
                        m_phi  = m_hi;
                        m_plo  = m_lo;
`endif
                    end else begin
                        m_left = 10;
                        if (mdu_op == 3'd3) begin
                            sq = sa / sb; sr = sa % sb;
                        end else begin
                            sq = longint'(src_a) / longint'(src_b);
                            sr = longint'(src_a) % longint'(src_b);
                        end
                        m_plo = sq[31:0];
                        m_phi = sr[31:0];
                    end
                end
                3'd5: m_hi = src_a;
                3'd6: m_lo = src_a;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
        chk("start", {31'd0, start},
            {31'd0, req_valid && mdu_op >= 3'd1 && mdu_op <= 3'd4 && m_left == 0});
        chk("hi_out", hi_out, m_hi);
        chk("lo_out", lo_out, m_lo);
        chk("rd_data", rd_data, read_hi ? m_hi : m_lo);
    end

    // Drive one request for one edge; called and returning at posedge+1.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1; mdu_op = op; src_a = a; src_b = b;
        @(posedge clk); #1;
        req_valid = 1'b0; mdu_op = 3'd0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            n_checks++; n_fail++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles", n);
        end
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi_out, 32'd0);
        chk("reset_lo", lo_out, 32'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        issue(3'd1, 32'hFFFF_FFFE, 32'd3); wait_idle(n);
        chk("mult_cycles", n, 32'd5);
        chk("mult_hi", hi_out, 32'hFFFF_FFFF);
        chk("mult_lo", lo_out, 32'hFFFF_FFFA);

        issue(3'd2, 32'hFFFF_FFFF, 32'd2); wait_idle(n);
        chk("multu_cycles", n, 32'd5);
        chk("multu_hi", hi_out, 32'h0000_0001);
        chk("multu_lo", lo_out, 32'hFFFF_FFFE);

        issue(3'd3, -32'sd7, 32'd2); wait_idle(n);
        chk("div_cycles", n, 32'd10);
        chk("div_hi", hi_out, 32'hFFFF_FFFF);
        chk("div_lo", lo_out, 32'hFFFF_FFFD);

        issue(3'd4, 32'd7, 32'd2); wait_idle(n);
        chk("divu_hi", hi_out, 32'd1);
        chk("divu_lo", lo_out, 32'd3);

        issue(3'd5, 32'h1234_5678, 32'd0);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_hi", hi_out, 32'h1234_5678);
        read_hi = 1'b1; #1;
        chk("mfhi", rd_data, 32'h1234_5678);
        read_hi = 1'b0; #1;
        chk("mflo", rd_data, 32'd3);

        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle(n);
        chk("ovf_hi", hi_out, 32'd0);
        chk("ovf_lo", lo_out, 32'h8000_0000);

        issue(3'd1, 32'd3, 32'd4);
        issue(3'd6, 32'h0000_DEAD, 32'd0);
        wait_idle(n);
        chk("mtlo_ignored_hi", hi_out, 32'd0);
        chk("mtlo_ignored_lo", lo_out, 32'd12);
        chk("busy_req_flagged", busy_req_seen, 32'd1);

        issue(3'd0, 32'd5, 32'd5);
        issue(3'd7, 32'd5, 32'd5);
        chk("none_busy", {31'd0, busy}, 32'd0);
        chk("none_hi", hi_out, 32'd0);
        chk("none_lo", lo_out, 32'd12);

        issue(3'd3, 32'd100, 32'd7);
        @(posedge clk); #3;
        reset = 1'b1; #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        @(negedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        issue(3'd1, 32'd6, 32'd7); wait_idle(n);
        chk("post_rst_cycles", n, 32'd5);
        chk("post_rst_hi", hi_out, 32'd0);
        chk("post_rst_lo", lo_out, 32'd42);

        issue(3'd5, 32'h11, 32'd0);
        issue(3'd6, 32'h22, 32'd0);
        issue(3'd3, 32'd9, 32'd0); wait_idle(n);
`ifdef MDU_DIVZERO_EN
        chk("dz_cycles", n, 32'd1);
        chk("dz_hi", hi_out, 32'd9);
        chk("dz_lo", lo_out, 32'hFFFF_FFFF);
        issue(3'd3, 32'hFFFF_FFFB, 32'd0); wait_idle(n);
        chk("dz_neg_hi", hi_out, 32'hFFFF_FFFB);
        chk("dz_neg_lo", lo_out, 32'd1);
        issue(3'd4, 32'd4, 32'd0); wait_idle(n);
        chk("dzu_hi", hi_out, 32'd4);
        chk("dzu_lo", lo_out, 32'hFFFF_FFFF);
`else
        chk("dz_cycles", n, 32'd10);
        chk("dz_hi", hi_out, 32'h11);
        chk("dz_lo", lo_out, 32'h22);
        issue(3'd4, 32'd4, 32'd0); wait_idle(n);
        chk("dzu_cycles", n, 32'd10);
        chk("dzu_hi", hi_out, 32'h11);
        chk("dzu_lo", lo_out, 32'h22);
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
